// File: rtl/mpmc10_pkg.sv
// Shared types for the mpmc10 memory controller: the Wishbone request
// record carried through the command FIFO and the channel arbiter states.
package mpmc10_pkg;

   localparam int MPMC10_NCH = 8;

   typedef struct packed {
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  adr;
      logic [127:0] dat;
   } wb_write_request128_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_PUSH,
      ARB_RELEASE
   } mpmc10_arb_state_t;

endpackage

// File: rtl/mpmc10_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of `eligible`
// strictly after `last`, wrapping around; with last=NCH-1 this is the lowest set bit.
module mpmc10_rr_pick #(
   parameter int NCH = 8
) (
   input  logic [NCH-1:0]         eligible,
   input  logic [$clog2(NCH)-1:0] last,
   output logic [$clog2(NCH)-1:0] pick,
   output logic                   any
);

   localparam int CW = $clog2(NCH);

   logic [CW-1:0] idx;

   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = CW'((int'(last) + k) % NCH);
         if (!any && eligible[idx]) begin
            any  = 1'b1;
            pick = idx;
         end
      end
   end

endmodule

// File: rtl/mpmc10_chan_arbiter_wb.sv
// Arbitrates NCH Wishbone channels onto the mpmc10 command FIFO: round-robin
// with a starvation override, posted writes, reads held pending until rd_done.
module mpmc10_chan_arbiter_wb
   import mpmc10_pkg::*;
#(
   parameter int NCH      = MPMC10_NCH,
   parameter int WAIT_W   = 6,
   parameter int MAX_WAIT = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  wb_write_request128_t     req [NCH],
   output logic [NCH-1:0]           wr_ack,
   input  logic [NCH-1:0]           rd_done,
   output logic [NCH-1:0]           rd_pend,
   input  logic                     fifo_full,
   output logic                     fifo_wr,
   output wb_write_request128_t     fifo_din,
   output logic [$clog2(NCH)-1:0]   fifo_chan,
   output logic                     busy
);

   localparam int                CW       = $clog2(NCH);
   localparam logic [CW-1:0]     LAST_CH  = CW'(NCH - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   mpmc10_arb_state_t state, state_nxt;

   logic [CW-1:0]     last;
   logic [WAIT_W-1:0] wait_cnt [NCH];
   logic [NCH-1:0]    valid, eligible, starved, held, rd_set;
   logic [CW-1:0]     rr_pick, st_pick, pick;
   logic              rr_any, st_any, grant;

   // fifo_chan doubles as the hold channel while a grant is in flight
   always_comb begin
      valid    = '0;
      eligible = '0;
      starved  = '0;
      held     = '0;
      rd_set   = '0;
      for (int i = 0; i < NCH; i++) begin
         valid[i]    = req[i].cyc & req[i].stb;
         held[i]     = (state != ARB_IDLE) && (fifo_chan == CW'(i));
         eligible[i] = valid[i] & ~rd_pend[i] & ~(held[i] && (state == ARB_RELEASE));
         starved[i]  = eligible[i] && (wait_cnt[i] >= WAIT_LIM);
      end
      if (fifo_wr && !fifo_din.we)
         rd_set[fifo_chan] = 1'b1;
   end

   mpmc10_rr_pick #(.NCH(NCH)) u_pick_starved (
      .eligible (starved),
      .last     (LAST_CH),
      .pick     (st_pick),
      .any      (st_any)
   );

   mpmc10_rr_pick #(.NCH(NCH)) u_pick_rr (
      .eligible (eligible),
      .last     (last),
      .pick     (rr_pick),
      .any      (rr_any)
   );

   assign pick  = st_any ? st_pick : rr_pick;
   assign grant = (state == ARB_IDLE) && rr_any && !fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:    if (grant) state_nxt = ARB_PUSH;
         ARB_PUSH:    if (!fifo_full) state_nxt = ARB_RELEASE;
         ARB_RELEASE: state_nxt = ARB_IDLE;
         default:     state_nxt = ARB_IDLE;
      endcase
   end

   always_comb begin
      fifo_wr = (state == ARB_PUSH) && !fifo_full;
      busy    = (state != ARB_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_din  <= '0;
         fifo_chan <= '0;
         last      <= LAST_CH;
         wr_ack    <= '0;
         rd_pend   <= '0;
      end else begin
         wr_ack  <= '0;
         rd_pend <= (rd_pend & ~rd_done) | rd_set;
         if (grant) begin
            fifo_din  <= req[pick];
            fifo_chan <= pick;
            last      <= pick;
         end
         if (fifo_wr && fifo_din.we)
            wr_ack[fifo_chan] <= 1'b1;
      end
   end

   // Waiting channels age every cycle; the one in flight is frozen until released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++)
            wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (grant && (pick == CW'(i)))
               wait_cnt[i] <= '0;
            else if (valid[i] && !rd_pend[i] && !held[i] && !(&wait_cnt[i]))
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mpmc10_chan_arbiter_wb.sv
// Scoreboard bench for mpmc10_chan_arbiter_wb: directed requests push the
// expected FIFO entries, a negedge monitor pops and checks each accepted push.
module tb_mpmc10_chan_arbiter_wb;
   import mpmc10_pkg::*;

   localparam int NCH = 8;
   localparam int CW  = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   wb_write_request128_t req [NCH];
   logic [NCH-1:0]       wr_ack;
   logic [NCH-1:0]       rd_done;
   logic [NCH-1:0]       rd_pend;
   logic                 fifo_full;
   logic                 fifo_wr;
   wb_write_request128_t fifo_din;
   logic [CW-1:0]        fifo_chan;
   logic                 busy;

   typedef struct {
      logic [CW-1:0]  chan;
      logic           we;
      logic [31:0]    adr;
      logic [127:0]   dat;
   } exp_t;

   exp_t           exp_q [$];
   int             n_cmp    = 0;
   int             n_bad    = 0;
   int             push_cnt = 0;
   logic           ack_due  = 1'b0;
   logic [NCH-1:0] exp_ack_next = '0;
   logic [31:0]    t4_adr;

   mpmc10_chan_arbiter_wb #(.NCH(NCH), .WAIT_W(6), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .wr_ack    (wr_ack),
      .rd_done   (rd_done),
      .rd_pend   (rd_pend),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din),
      .fifo_chan (fifo_chan),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, want);
      end
   endtask

   function automatic wb_write_request128_t makeReq(input logic we, input logic [31:0] adr);
      wb_write_request128_t r;
      r     = '0;
      r.cyc = 1'b1;
      r.stb = 1'b1;
      r.we  = we;
      r.sel = '1;
      r.adr = adr;
      r.dat = {adr, ~adr, adr + 32'd1, 32'hDEAD_BEEF};
      return r;
   endfunction

   task automatic applyStimulus(input int ch, input logic we, input logic [31:0] adr, input bit exp_push);
      exp_t e;
      req[ch] = makeReq(we, adr);
      if (exp_push) begin
         e.chan = CW'(ch);
         e.we   = we;
         e.adr  = adr;
         e.dat  = req[ch].dat;
         exp_q.push_back(e);
      end
   endtask

   task automatic dropAll();
      for (int i = 0; i < NCH; i++)
         req[i] = '0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      checkOutput("queue_empty_at_reset", 128'(exp_q.size()), 128'd0);
      rst       = 1'b1;
      fifo_full = 1'b0;
      rd_done   = '0;
      dropAll();
      push_cnt  = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic waitPushes(input int target, input int budget, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (push_cnt < target && n < budget);
      #1;
      if (push_cnt < target) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL %s timeout: pushes %0d required %0d", name, push_cnt, target);
      end
   endtask

   // Monitor: every accepted push is matched against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            ack_due = 1'b0;
         end else begin
            if (ack_due) begin
               checkOutput("wr_ack_after_push", wr_ack, exp_ack_next);
               ack_due = 1'b0;
            end else if (wr_ack != '0) begin
               checkOutput("stray_wr_ack", wr_ack, '0);
            end
            if (fifo_full)
               checkOutput("fifo_wr_while_full", fifo_wr, 1'b0);
            if (fifo_wr && !fifo_full) begin
               push_cnt++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("[TB] FAIL unexpected_push: actual chan %0d required none", fifo_chan);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("push_chan", fifo_chan, e.chan);
                  checkOutput("push_we", fifo_din.we, e.we);
                  checkOutput("push_adr", fifo_din.adr, e.adr);
                  checkOutput("push_dat", fifo_din.dat, e.dat);
                  ack_due      = 1'b1;
                  exp_ack_next = e.we ? NCH'(1 << e.chan) : '0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst       = 1'b1;
      fifo_full = 1'b0;
      rd_done   = '0;
      dropAll();

      // Reset values and single write latency
      @(negedge clk);
      checkOutput("rst_fifo_wr", fifo_wr, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_wr_ack", wr_ack, '0);
      checkOutput("rst_rd_pend", rd_pend, '0);
      checkOutput("rst_fifo_chan", fifo_chan, '0);
      checkOutput("rst_fifo_din_adr", fifo_din.adr, '0);
      doReset();
      applyStimulus(3, 1'b1, 32'h0000_3000, 1'b1);
      @(negedge clk);
      checkOutput("t1_c1_fifo_wr", fifo_wr, 1'b0);
      nextCycle();
      @(negedge clk);
      checkOutput("t1_c2_fifo_wr", fifo_wr, 1'b1);
      checkOutput("t1_c2_fifo_chan", fifo_chan, 3'd3);
      nextCycle();
      dropAll();
      @(negedge clk);
      checkOutput("t1_c3_wr_ack", wr_ack, 8'h08);
      checkOutput("t1_c3_busy", busy, 1'b1);
      nextCycle();
      @(negedge clk);
      checkOutput("t1_c4_busy", busy, 1'b0);
      checkOutput("t1_c4_wr_ack", wr_ack, 8'h00);

      // Round-robin among channels 0, 2 and 5
      doReset();
      applyStimulus(0, 1'b1, 32'h0000_0A00, 1'b0);
      applyStimulus(2, 1'b1, 32'h0000_0A02, 1'b0);
      applyStimulus(5, 1'b1, 32'h0000_0A05, 1'b0);
      for (int r = 0; r < 2; r++) begin
         applyStimulus(0, 1'b1, 32'h0000_0A00, 1'b1);
         applyStimulus(2, 1'b1, 32'h0000_0A02, 1'b1);
         applyStimulus(5, 1'b1, 32'h0000_0A05, 1'b1);
      end
      waitPushes(6, 40, "t2_rr");
      dropAll();
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("t2_idle_busy", busy, 1'b0);

      // Read is masked while pending, cleared by rd_done
      doReset();
      applyStimulus(1, 1'b0, 32'h0000_1100, 1'b1);
      waitPushes(1, 20, "t3_read");
      @(negedge clk);
      checkOutput("t3_rd_pend_set", rd_pend, 8'h02);
      repeat (6) nextCycle();
      @(negedge clk);
      checkOutput("t3_masked_busy", busy, 1'b0);
      checkOutput("t3_rd_pend_held", rd_pend, 8'h02);
      nextCycle();
      rd_done[1] = 1'b1;
      dropAll();
      @(negedge clk);
      checkOutput("t3_rd_pend_before_clear", rd_pend, 8'h02);
      nextCycle();
      rd_done = '0;
      @(negedge clk);
      checkOutput("t3_rd_pend_cleared", rd_pend, 8'h00);

      // FIFO full stalls the push; dropping stb does not cancel it
      doReset();
      t4_adr = 32'h0000_4440;
      applyStimulus(4, 1'b1, t4_adr, 1'b1);
      nextCycle();
      fifo_full = 1'b1;
      dropAll();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("t4_stall_fifo_wr", fifo_wr, 1'b0);
         checkOutput("t4_stall_busy", busy, 1'b1);
         checkOutput("t4_stall_din_adr", fifo_din.adr, t4_adr);
         checkOutput("t4_stall_chan", fifo_chan, 3'd4);
         nextCycle();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      checkOutput("t4_push_after_full", fifo_wr, 1'b1);
      nextCycle();
      @(negedge clk);
      checkOutput("t4_wr_ack", wr_ack, 8'h10);

      // Starvation override: ch7 aged behind a full FIFO beats round-robin's ch0
      doReset();
      fifo_full = 1'b1;
      applyStimulus(7, 1'b1, 32'h0000_7700, 1'b1);
      repeat (5) nextCycle();
      fifo_full = 1'b0;
      for (int i = 0; i < 7; i++)
         applyStimulus(i, 1'b1, 32'h0000_5500 + 32'(i), (i < 2));
      waitPushes(3, 30, "t5_starve");
      dropAll();
      repeat (3) nextCycle();

      // Async reset in the middle of a stalled push with reads pending
      doReset();
      applyStimulus(1, 1'b0, 32'h0000_6100, 1'b1);
      applyStimulus(3, 1'b0, 32'h0000_6300, 1'b1);
      waitPushes(2, 30, "t6_reads");
      @(negedge clk);
      checkOutput("t6_rd_pend", rd_pend, 8'h0A);
      nextCycle();
      applyStimulus(5, 1'b1, 32'h0000_6500, 1'b0);
      nextCycle();
      fifo_full = 1'b1;
      @(negedge clk);
      checkOutput("t6_in_push", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6_async_busy", busy, 1'b0);
      checkOutput("t6_async_fifo_wr", fifo_wr, 1'b0);
      checkOutput("t6_async_rd_pend", rd_pend, 8'h00);
      checkOutput("t6_async_wr_ack", wr_ack, 8'h00);
      checkOutput("t6_async_chan", fifo_chan, 3'd0);
      checkOutput("t6_async_din_zero", 128'(fifo_din != '0), 128'd0);
      dropAll();
      fifo_full = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("t6_post_wr_ack", wr_ack, 8'h00);
         checkOutput("t6_post_rd_pend", rd_pend, 8'h00);
         nextCycle();
      end

      checkOutput("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
